fetch_unit: RTL

Instruction fetch stage for the single-cycle-memory MIPS datapath. Holds the program counter, presents it as a word index to the combinational instruction memory, and registers the returned 32-bit instruction into an IF/ID pipeline register for decode. Handles sequential fetch, stall, branch and jump redirects, squash of the wrong-path instruction, and end-of-program halt.

---
 rtl/fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory
// and fills the IF/ID register, with stall, branch/jump redirect and end-of-program halt.
module fetch_unit #(
  parameter int PROG_LEN = 7
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] program_counter,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic [31:0] branch_pc_plus1,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus1_out,
  output logic        valid_out,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [31:0] PROG_END = 32'(PROG_LEN);

  logic [1:0]  state;
  logic        redirect;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [31:0] redirect_addr;
  logic [31:0] pc_seq;

  assign pc_seq        = program_counter + 32'd1;
  assign branch_addr   = branch_pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
  assign jump_addr     = {branch_pc_plus1[31:26], jump_target};
  assign redirect      = jump | branch_taken;
  // Jump outranks branch; either one outranks stall.
  assign redirect_addr = jump ? jump_addr : branch_addr;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      program_counter <= '0;
      instr_out       <= '0;
      pc_plus1_out    <= '0;
      valid_out       <= 1'b0;
      halted          <= 1'b0;
      fetch_count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          valid_out <= 1'b0;
        end
        S_FETCH, S_HALTED: begin
          if (redirect) begin
            // Squash the wrong-path fetch; IF/ID payload is left as-is.
            program_counter <= redirect_addr;
            valid_out       <= 1'b0;
            halted          <= 1'b0;
            state           <= S_FETCH;
          end else if (state == S_FETCH && !stall) begin
            if (program_counter < PROG_END) begin
              instr_out       <= instruction;
              pc_plus1_out    <= pc_seq;
              valid_out       <= 1'b1;
              fetch_count     <= fetch_count + 32'd1;
              program_counter <= pc_seq;
            end else begin
              valid_out <= 1'b0;
              halted    <= 1'b1;
              state     <= S_HALTED;
            end
          end else if (state == S_HALTED) begin
            valid_out <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
